// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one spi_master among NUM_REQ burst requesters
module spi_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int CS_GUARD   = 2,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic [NUM_REQ-1:0]            wr_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_ready,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          timeout,
  output logic [NUM_REQ-1:0]            dev_cs_n,
  output logic [DATA_WIDTH-1:0]         m_tx_data,
  output logic                          m_start,
  input  logic                          m_busy,
  input  logic                          m_done,
  input  logic [DATA_WIDTH-1:0]         m_rx_data
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = $clog2(CS_GUARD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [NUM_REQ-1:0] ONE = 1;
  typedef enum logic [2:0] {IDLE, CS_SETUP, WAIT_BYTE, XFER, CS_HOLD} state_t;
  state_t state;
  logic [IW-1:0] ptr, g, pick, idx;
  logic [GW-1:0] guard_cnt;
  logic [TW-1:0] idle_cnt;
  logic [BW-1:0] byte_cnt;
  logic guard_done;
  assign guard_done = guard_cnt == GW'(CS_GUARD - 1);
  // first requesting index after the last owner, scanning with wrap; the nearest match wins
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) pick = idx;
    end
  end
  // burst FSM: grant, chip-select guard, byte streaming, forced release on burst limit or idle timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IW'(NUM_REQ - 1);
      g         <= '0;
      gnt       <= '0;
      wr_ready  <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
      timeout   <= 1'b0;
      dev_cs_n  <= '1;
      m_tx_data <= '0;
      m_start   <= 1'b0;
      guard_cnt <= '0;
      idle_cnt  <= '0;
      byte_cnt  <= '0;
    end else begin
      wr_ready <= '0;
      rd_valid <= '0;
      m_start  <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          g         <= pick;
          gnt       <= ONE << pick;
          dev_cs_n  <= ~(ONE << pick);
          guard_cnt <= '0;
          idle_cnt  <= '0;
          state     <= CS_SETUP;
        end
        CS_SETUP: begin
          guard_cnt <= guard_done ? '0 : guard_cnt + 1'b1;
          if (guard_done) state <= WAIT_BYTE;
        end
        WAIT_BYTE: if (!req[g]) state <= CS_HOLD;
          else if (wr_valid[g]) begin
            if (!m_busy) begin
              wr_ready  <= ONE << g;
              m_start   <= 1'b1;
              m_tx_data <= wr_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
              idle_cnt  <= '0;
              state     <= XFER;
            end
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            timeout  <= 1'b1;
            idle_cnt <= '0;
            state    <= CS_HOLD;
          end else idle_cnt <= idle_cnt + 1'b1;
        XFER: if (m_done) begin
          rd_valid <= ONE << g;
          rd_data  <= m_rx_data;
          byte_cnt <= byte_cnt + 1'b1;
          state    <= byte_cnt == BW'(MAX_BURST - 1) ? CS_HOLD : WAIT_BYTE;
        end
        CS_HOLD: begin
          guard_cnt <= guard_done ? '0 : guard_cnt + 1'b1;
          if (guard_done) begin
            dev_cs_n <= '1;
            gnt      <= '0;
            ptr      <= g;
            byte_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one spi_master instance between NUM_REQ requesters using round-robin arbitration.
- Each requester wins ownership for a multi-byte burst. It streams bytes through a valid/ready handshake and receives each RX byte back.
- The arbiter drives a dedicated per-device chip-select that stays low for the whole burst. The spi_master's own spi_cs_n is left unconnected at top level.
- Sits between the requesters (command engines, config loaders) and spi_master.

Parameters:
- NUM_REQ, 2, number of requesters and device chip-selects (2..8)
- DATA_WIDTH, 8, byte width; must match spi_master
- CS_GUARD, 2, clk cycles cs_n is held low before the first start and after the last done
- MAX_BURST, 4, maximum bytes per grant before forced release (fairness)
- TIMEOUT, 64, idle clk cycles in WAIT_BYTE before forced release

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  NUM_REQ  per-requester bus request; held high for the whole burst
- gnt  out  NUM_REQ  one-hot grant
- wr_valid  in  NUM_REQ  requester has a byte to send
- wr_data  in  NUM_REQ*DATA_WIDTH  flattened TX bytes; slice i belongs to requester i
- wr_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- rd_valid  out  NUM_REQ  one-cycle RX byte pulse to the granted requester
- rd_data  out  DATA_WIDTH  RX byte; valid while any rd_valid bit is high
- timeout  out  1  one-cycle pulse on a TIMEOUT-forced release
- dev_cs_n  out  NUM_REQ  active-low device chip-selects
- m_tx_data  out  DATA_WIDTH  to spi_master tx_data
- m_start  out  1  to spi_master start
- m_busy  in  1  from spi_master busy
- m_done  in  1  from spi_master done
- m_rx_data  in  DATA_WIDTH  from spi_master rx_data

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high (rst).
- Reset values: gnt=0, wr_ready=0, rd_valid=0, rd_data=0, timeout=0, dev_cs_n=all 1, m_tx_data=0, m_start=0, state=IDLE, rr pointer=NUM_REQ-1, counters=0.
- Reset mid-transfer: the above values apply immediately. No rd_valid is issued for the aborted byte. The spi_master is reset by its own reset.
- All outputs are registered.

State machine:
- IDLE:
  - If any req bit is set, grant the first set bit searching from pointer+1 with wrap.
  - Next cycle: gnt[g]=1, dev_cs_n[g]=0, guard counter cleared, go to CS_SETUP.
  - Request-to-grant latency is 1 cycle.
- CS_SETUP: wait CS_GUARD cycles, then go to WAIT_BYTE.
- WAIT_BYTE:
  - If req[g]=0: go to CS_HOLD.
  - Else if wr_valid[g]=1: next cycle pulse wr_ready[g] and m_start together, m_tx_data = wr_data slice g, then go to XFER. m_start is issued only when m_busy=0; otherwise the arbiter stays in WAIT_BYTE.
  - Else: increment the idle counter. On reaching TIMEOUT, pulse timeout and go to CS_HOLD.
  - The idle counter clears on every byte accept.
- XFER:
  - On m_done: next cycle rd_valid[g]=1 and rd_data=m_rx_data; byte_cnt increments.
  - If byte_cnt reaches MAX_BURST, go to CS_HOLD; otherwise go to WAIT_BYTE.
- CS_HOLD:
  - Hold dev_cs_n low for CS_GUARD cycles.
  - Then set dev_cs_n[g]=1 and gnt=0, set pointer=g, clear byte_cnt, go to IDLE.
  - This guarantees at least 1 cycle with cs_n high between bursts, including regrant to the same requester.

Handshake and requester rules:
- Requesters hold wr_valid and wr_data stable until wr_ready.
- wr_valid from non-granted requesters is ignored.
- req dropping during XFER takes effect only after the current byte completes, and rd_valid is still delivered.
- wr_ready and rd_valid never assert for a non-granted index.
- At most one byte is in flight at a time.

Test Plan:
- Loopback model: spi_master at CLK_FREQ 10 MHz, SPI_FREQ 1 MHz, MISO tied to MOSI. Requester 0 bursts 0xA5 then 0x3C, then drops req.
  -> rd_valid[0] twice with rd_data 0xA5, then 0x3C.
  -> dev_cs_n=2'b10 continuously from CS_SETUP through CS_HOLD, returning to 2'b11.
  -> gnt[1], wr_ready[1] and rd_valid[1] never asserted.
- req=2'b11 the cycle after reset -> gnt=2'b01 first. After release -> gnt=2'b10. Both re-requesting -> gnt=2'b01 again (round-robin).
- Requester 0 offers 6 bytes 0x01..0x06 while req[1] is held.
  -> forced release after 0x04.
  -> requester 1 served next.
  -> requester 0 regranted afterwards and completes 0x05, 0x06 with correct loopback data.
- Requester 1 granted, no wr_valid for 64 cycles -> single timeout pulse, dev_cs_n[1] high after CS_GUARD, gnt=0.
- rst asserted mid-XFER -> same cycle: gnt=0, dev_cs_n=all 1, m_start=0, no rd_valid. After deassert, a new burst completes normally.
- wr_valid[1]=1 while requester 0 is granted -> wr_ready[1] stays 0 until requester 1 holds the grant, then accepts its byte.
